// File: rtl/csr_trap_controller_if.sv
// Pipeline-facing bus of the machine-mode CSR/trap controller: CSR read/write ports,
// trap/mret events, interrupt lines and the redirect handshake toward flush logic.
interface csr_trap_controller_if #(
  parameter int W = 64
);
  logic         i_clk_en;
  logic [11:0]  i_csr_addr;
  logic [W-1:0] o_csr_rdata;
  logic         o_csr_illegal;
  logic         i_csr_we;
  logic [11:0]  i_csr_waddr;
  logic [W-1:0] i_csr_wdata;
  logic         i_exc_valid;
  logic [3:0]   i_exc_code;
  logic [W-1:0] i_exc_pc;
  logic [W-1:0] i_exc_tval;
  logic         i_mret;
  logic         i_irq_safe;
  logic [W-1:0] i_irq_pc;
  logic         i_meip;
  logic         i_msip;
  logic         i_mtip;
  logic         i_instr_retired;
  logic         o_redirect_valid;
  logic [W-1:0] o_redirect_pc;
  logic         i_redirect_ready;
  logic         o_busy;

  modport master (
    output i_clk_en, i_csr_addr, i_csr_we, i_csr_waddr, i_csr_wdata,
           i_exc_valid, i_exc_code, i_exc_pc, i_exc_tval, i_mret,
           i_irq_safe, i_irq_pc, i_meip, i_msip, i_mtip, i_instr_retired,
           i_redirect_ready,
    input  o_csr_rdata, o_csr_illegal, o_redirect_valid, o_redirect_pc, o_busy
  );

  modport slave (
    input  i_clk_en, i_csr_addr, i_csr_we, i_csr_waddr, i_csr_wdata,
           i_exc_valid, i_exc_code, i_exc_pc, i_exc_tval, i_mret,
           i_irq_safe, i_irq_pc, i_meip, i_msip, i_mtip, i_instr_retired,
           i_redirect_ready,
    output o_csr_rdata, o_csr_illegal, o_redirect_valid, o_redirect_pc, o_busy
  );
endinterface

// File: rtl/csr_trap_controller.sv
// Machine-mode CSR file with trap sequencer: interrupt arbitration, direct/vectored
// mtvec, 64-bit mcycle/minstret, and a valid/ready redirect toward the flush logic.
module csr_trap_controller #(
  parameter logic [1:0] XLEN = 2'b10,
  parameter logic [(1 << (int'(XLEN) + 4)) - 1:0] MTVEC_RESET = '0,
  parameter bit COUNTERS_EN = 1'b1
) (
  input logic i_clk,
  input logic i_rst,
  csr_trap_controller_if.slave bus
);
  localparam int W = 1 << (int'(XLEN) + 4);
  localparam logic [W-1:0] ALIGN_MASK = {{(W-2){1'b1}}, 2'b00};

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {S_IDLE, S_TRAP, S_RET, S_ACK} state_e;

  state_e       state_q, state_d;
  logic         st_mie_q, st_mie_d;
  logic         st_mpie_q, st_mpie_d;
  logic [2:0]   mie_q, mie_d;  // {MEIE, MTIE, MSIE}
  logic [W-1:0] mtvec_q, mtvec_d;
  logic [W-1:0] mepc_q, mepc_d;
  logic [W-1:0] mcause_q, mcause_d;
  logic [W-1:0] mtval_q, mtval_d;
  logic [W-1:0] mscratch_q, mscratch_d;
  logic [63:0]  mcycle_q, mcycle_d;
  logic [63:0]  minstret_q, minstret_d;
  logic         redirect_valid_q, redirect_valid_d;
  logic [W-1:0] redirect_pc_q, redirect_pc_d;

  logic [2:0]   irq_pend;
  logic         irq;
  logic [3:0]   irq_id;
  logic [W-1:0] trap_base;
  logic [W-1:0] trap_target;
  logic         take_trap;
  logic         we_hit;

  // Interrupt arbitration: MEI > MSI > MTI
  always_comb begin
    irq_pend = {bus.i_meip, bus.i_mtip, bus.i_msip} & mie_q;
    irq      = st_mie_q & (|irq_pend) & bus.i_irq_safe;
    if (irq_pend[2])      irq_id = 4'd11;
    else if (irq_pend[0]) irq_id = 4'd3;
    else                  irq_id = 4'd7;
  end

  // Combinational read port; no bypass of a same-cycle write
  always_comb begin
    bus.o_csr_rdata   = '0;
    bus.o_csr_illegal = 1'b0;
    case (bus.i_csr_addr)
      A_MSTATUS: begin
        bus.o_csr_rdata[12:11] = 2'b11;
        bus.o_csr_rdata[7]     = st_mpie_q;
        bus.o_csr_rdata[3]     = st_mie_q;
      end
      A_MIE: begin
        bus.o_csr_rdata[11] = mie_q[2];
        bus.o_csr_rdata[7]  = mie_q[1];
        bus.o_csr_rdata[3]  = mie_q[0];
      end
      A_MIP: begin
        bus.o_csr_rdata[11] = bus.i_meip;
        bus.o_csr_rdata[7]  = bus.i_mtip;
        bus.o_csr_rdata[3]  = bus.i_msip;
      end
      A_MTVEC:    bus.o_csr_rdata = mtvec_q;
      A_MSCRATCH: bus.o_csr_rdata = mscratch_q;
      A_MEPC:     bus.o_csr_rdata = mepc_q;
      A_MCAUSE:   bus.o_csr_rdata = mcause_q;
      A_MTVAL:    bus.o_csr_rdata = mtval_q;
      A_MCYCLE:   bus.o_csr_rdata = mcycle_q[W-1:0];
      A_MINSTRET: bus.o_csr_rdata = minstret_q[W-1:0];
      A_MCYCLEH: begin
        if (W == 32) bus.o_csr_rdata = W'(mcycle_q[63:32]);
        else         bus.o_csr_illegal = 1'b1;
      end
      A_MINSTRETH: begin
        if (W == 32) bus.o_csr_rdata = W'(minstret_q[63:32]);
        else         bus.o_csr_illegal = 1'b1;
      end
      default: bus.o_csr_illegal = 1'b1;
    endcase
  end

  // Counters: a write to either half replaces that cycle's increment
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, bus.i_instr_retired};
    if (bus.i_csr_we) begin
      if (W == 32) begin
        case (bus.i_csr_waddr)
          A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], bus.i_csr_wdata[31:0]};
          A_MCYCLEH:   mcycle_d   = {bus.i_csr_wdata[31:0], mcycle_q[31:0]};
          A_MINSTRET:  minstret_d = {minstret_q[63:32], bus.i_csr_wdata[31:0]};
          A_MINSTRETH: minstret_d = {bus.i_csr_wdata[31:0], minstret_q[31:0]};
          default: ;
        endcase
      end else begin
        if (bus.i_csr_waddr == A_MCYCLE)   mcycle_d   = 64'(bus.i_csr_wdata);
        if (bus.i_csr_waddr == A_MINSTRET) minstret_d = 64'(bus.i_csr_wdata);
      end
    end
    if (!COUNTERS_EN) begin
      mcycle_d   = '0;
      minstret_d = '0;
    end
  end

  // CSR writes first, then trap/mret updates override them
  always_comb begin
    // NOTE: every _d gets its hold value before any branch, so no path can infer a latch.
    state_d          = state_q;
    st_mie_d         = st_mie_q;
    st_mpie_d        = st_mpie_q;
    mie_d            = mie_q;
    mtvec_d          = mtvec_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    mtval_d          = mtval_q;
    mscratch_d       = mscratch_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    take_trap        = 1'b0;
    we_hit           = bus.i_csr_we;
    trap_base        = mtvec_q & ALIGN_MASK;
    trap_target      = trap_base;

    if (we_hit) begin
      case (bus.i_csr_waddr)
        A_MSTATUS: begin
          st_mie_d  = bus.i_csr_wdata[3];
          st_mpie_d = bus.i_csr_wdata[7];
        end
        A_MIE: mie_d = {bus.i_csr_wdata[11], bus.i_csr_wdata[7], bus.i_csr_wdata[3]};
        A_MTVEC: begin
          mtvec_d = bus.i_csr_wdata;
          if (bus.i_csr_wdata[1:0] >= 2'd2) mtvec_d[1:0] = mtvec_q[1:0];
        end
        A_MEPC:     mepc_d     = bus.i_csr_wdata & ALIGN_MASK;
        A_MCAUSE:   mcause_d   = bus.i_csr_wdata;
        A_MTVAL:    mtval_d    = bus.i_csr_wdata;
        A_MSCRATCH: mscratch_d = bus.i_csr_wdata;
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (bus.i_exc_valid) begin
          take_trap = 1'b1;
          mepc_d    = bus.i_exc_pc & ALIGN_MASK;
          mcause_d  = W'(bus.i_exc_code);
          mtval_d   = bus.i_exc_tval;
        end else if (irq) begin
          take_trap = 1'b1;
          mepc_d    = bus.i_irq_pc & ALIGN_MASK;
          mcause_d  = {1'b1, (W-1)'(irq_id)};
          mtval_d   = '0;
          if (mtvec_q[1:0] == 2'b01) trap_target = trap_base + W'({irq_id, 2'b00});
        end else if (bus.i_mret) begin
          st_mie_d         = st_mpie_q;
          st_mpie_d        = 1'b1;
          redirect_pc_d    = mepc_q;
          redirect_valid_d = 1'b1;
          state_d          = S_RET;
        end
        if (take_trap) begin
          st_mpie_d        = st_mie_q;
          st_mie_d         = 1'b0;
          redirect_pc_d    = trap_target;
          redirect_valid_d = 1'b1;
          state_d          = S_TRAP;
        end
      end
      S_TRAP, S_RET, S_ACK: begin
        // Ready may already be high in the first valid cycle
        if (bus.i_redirect_ready) begin
          redirect_valid_d = 1'b0;
          state_d          = S_IDLE;
        end else begin
          state_d = S_ACK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q          <= S_IDLE;
      st_mie_q         <= 1'b0;
      st_mpie_q        <= 1'b0;
      mie_q            <= '0;
      mtvec_q          <= MTVEC_RESET & ALIGN_MASK;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      mscratch_q       <= '0;
      mcycle_q         <= '0;
      minstret_q       <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else if (bus.i_clk_en) begin
      // NOTE: non-blocking updates so every register samples pre-edge values of the others.
      state_q          <= state_d;
      st_mie_q         <= st_mie_d;
      st_mpie_q        <= st_mpie_d;
      mie_q            <= mie_d;
      mtvec_q          <= mtvec_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      mtval_q          <= mtval_d;
      mscratch_q       <= mscratch_d;
      mcycle_q         <= mcycle_d;
      minstret_q       <= minstret_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign bus.o_redirect_valid = redirect_valid_q;
  assign bus.o_redirect_pc    = redirect_pc_q;
  assign bus.o_busy           = (state_q != S_IDLE);
endmodule

// File: doc/csr_trap_controller.md
Name: csr_trap_controller

Overview:
- Machine-mode CSR file with a trap sequencer.
- Replaces the fixed-width CSR regfile path and adds:
  - interrupt arbitration (MEI/MSI/MTI),
  - direct/vectored mtvec,
  - mcycle/minstret counters,
  - a redirect handshake to the pipeline flush logic.
- Sits beside decode: a combinational read port serves CSR instructions, the write port is driven from writeback, and trap/mret events arrive from execute.

Parameters:
- XLEN, `XLEN_64b, width encoding; data width W = 1<<(XLEN+4), so 2'b01 gives 32 and 2'b10 gives 64.
- MTVEC_RESET, 0, reset value of mtvec (W bits; bits [1:0] ignored).
- COUNTERS_EN, 1, 0 removes mcycle/minstret, which then read 0.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_clk_en  in  1  global stall; low freezes all state
- i_csr_addr  in  12  read address (decode)
- o_csr_rdata  out  W  combinational read data; 0 for unimplemented addresses
- o_csr_illegal  out  1  address not implemented (combinational)
- i_csr_we  in  1  write enable (writeback)
- i_csr_waddr  in  12  write address
- i_csr_wdata  in  W  write data, already op-merged by decode
- i_exc_valid  in  1  synchronous exception
- i_exc_code  in  4  mcause code
- i_exc_pc  in  W  faulting pc
- i_exc_tval  in  W  mtval value
- i_mret  in  1  mret in execute
- i_irq_safe  in  1  pipeline may take an interrupt this cycle
- i_irq_pc  in  W  pc to save on interrupt
- i_meip, i_msip, i_mtip  in  1 each  level interrupt lines
- i_instr_retired  in  1  one instruction retired this cycle
- o_redirect_valid  out  1  redirect request
- o_redirect_pc  out  W  redirect target
- i_redirect_ready  in  1  flush accepted
- o_busy  out  1  FSM not IDLE

Behaviour:
- Reset (async, immediate):
  - FSM=IDLE; mstatus.MIE=0, MPIE=0; mie=0; mepc/mcause/mtval/mscratch/mcycle/minstret=0; mtvec=MTVEC_RESET.
  - o_redirect_valid=0, o_redirect_pc=0, o_busy=0.
- CSRs implemented:
  - mstatus: MIE bit3, MPIE bit7; MPP[12:11] reads 2'b11; all other bits read 0.
  - mie: bits 3/7/11 writable.
  - mip: bits 3/7/11 mirror the inputs; writes ignored.
  - mtvec: a write with mode [1:0] >= 2 keeps the old mode and updates the base.
  - mepc: bits [1:0] forced 0.
  - mcause, mtval, mscratch.
  - mcycle, minstret; when W=32, also mcycleh/minstreth as the upper halves of 64-bit counters.
- Read/write timing:
  - Reads are combinational from current state.
  - A write lands on the next edge with i_clk_en=1.
  - No internal read-during-write bypass.
- Counters (per enabled cycle):
  - mcycle increments by 1.
  - minstret increments when i_instr_retired.
  - A CSR write to either half takes priority over the increment that cycle; 64-bit wrap to 0.
- Interrupt request: irq = mstatus.MIE & |(mip & mie) & i_irq_safe; priority MEI(11) > MSI(3) > MTI(7).
- FSM IDLE, event priority (highest first):
  1. i_exc_valid → TRAP; saves mepc=i_exc_pc, mcause={0,code}, mtval=i_exc_tval.
  2. irq → TRAP; saves mepc=i_irq_pc, mcause={1,id}, mtval=0.
  3. i_mret → RET.
  - A same-cycle i_csr_we to mepc/mcause/mtval/mstatus is overridden by the trap update.
- TRAP (1 cycle):
  - MPIE<=MIE, MIE<=0.
  - Target = base; for vectored mode with an interrupt, target = base + 4*id.
  - Load o_redirect_pc, assert o_redirect_valid → ACK.
- RET (1 cycle):
  - MIE<=MPIE, MPIE<=1.
  - o_redirect_pc=mepc, assert valid → ACK.
- ACK:
  - Hold valid and pc stable until i_redirect_ready=1.
  - Valid drops on the next edge → IDLE.
  - New events are ignored while not IDLE; the pipeline is held by o_busy.
- Pipelining: ready may already be high when valid rises, giving a minimum 1-cycle handshake; event to valid latency is 1 enabled cycle.
- i_clk_en=0 freezes FSM, counters and writes; outputs stay stable.
- Reset in any state returns to IDLE with valid low immediately.

Test Plan:
- Reset, then read mtvec, mstatus, mcycle → MTVEC_RESET, 0x1800, 0; after 10 enabled cycles mcycle=10; after 5 cycles with clk_en=0 it still reads 10.
- mtvec=0x100 (direct): exception code 2, pc 0x80, tval 0xDEAD → redirect 0x100 one cycle later; mepc=0x80, mcause=2, mtval=0xDEAD, MIE 1→0, MPIE=1; valid held until ready.
- mtvec=0x201 (vectored), MIE=1, mie=0x888, MTIP and MEIP both high, irq_safe=1 → mcause=0x8…0B, redirect 0x22C; repeat with MTIP only → 0x21C.
- Simultaneous exception, irq and mret → exception path only; a CSR write to mepc in the same cycle is lost.
- mret after trap → redirect to mepc, MIE restored to 1, MPIE=1; W=32 build: mcycle 0xFFFFFFFF → next cycle mcycleh=1, mcycle=0.
- Assert i_rst while in ACK → o_redirect_valid=0 the same cycle, o_busy=0, FSM IDLE.
